// File: rtl/kpwebb_multi_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : kpwebb_multi_accum_if
// Description : Command/result handshake bundle for the multi-channel accumulator
// Revision    : 1.0 - initial release
// ============================================================================
interface kpwebb_multi_accum_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   localparam int CH_W = $clog2(CHANNELS);

   logic              in_valid;
   logic              in_ready;
   logic [1:0]        op;
   logic [CH_W-1:0]   chan_sel;
   logic [WIDTH-1:0]  operand;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  result;
   logic [CH_W-1:0]   result_chan;
   logic              result_ovf;

   modport master (
      output in_valid, op, chan_sel, operand, out_ready,
      input  in_ready, out_valid, result, result_chan, result_ovf
   );

   modport slave (
      input  in_valid, op, chan_sel, operand, out_ready,
      output in_ready, out_valid, result, result_chan, result_ovf
   );
endinterface
`default_nettype wire

// File: rtl/kpwebb_multi_accum.sv
`default_nettype none
// ============================================================================
// Module      : kpwebb_multi_accum
// Description : CHANNELS independent WIDTH-bit accumulators with ADD/SUB/LOAD/READ
//               commands, a one-entry result buffer and per-channel overflow flags
// Revision    : 1.0 - initial release
// ============================================================================
module kpwebb_multi_accum #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SATURATE = 0
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   input  wire logic                ena,
   kpwebb_multi_accum_if.slave      bus,
   output logic [CHANNELS-1:0]      sticky_ovf
);
   localparam int CH_W = $clog2(CHANNELS);

   localparam logic [1:0] c_OP_ADD  = 2'b00;
   localparam logic [1:0] c_OP_SUB  = 2'b01;
   localparam logic [1:0] c_OP_LOAD = 2'b10;
   localparam logic [1:0] c_OP_READ = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [1:0]        r_op;
   logic [CH_W-1:0]   r_chan;
   logic [WIDTH-1:0]  r_operand;
   logic [WIDTH-1:0]  r_acc [CHANNELS];
   logic [CHANNELS-1:0] r_sticky;
   logic [WIDTH-1:0]  r_result;
   logic [CH_W-1:0]   r_result_chan;
   logic              r_result_ovf;

   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_accept;
   logic [WIDTH-1:0]  w_acc_cur;
   logic [WIDTH:0]    w_sum;
   logic [WIDTH:0]    w_diff;
   logic [WIDTH-1:0]  w_new;
   logic              w_ovf;

   // in_ready is gated by ena so a frozen design never takes a command
   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = ena;
            if (bus.in_valid) w_next = S_EXEC;
         end
         S_EXEC: w_next = S_RESP;
         S_RESP: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (ena) begin
         r_state <= w_next;
      end
   end

   assign w_accept = w_in_ready & bus.in_valid;

   // One extra bit captures ADD carry and SUB borrow alike
   always_comb begin
      w_acc_cur = r_acc[r_chan];
      w_sum     = {1'b0, w_acc_cur} + {1'b0, r_operand};
      w_diff    = {1'b0, w_acc_cur} - {1'b0, r_operand};
      w_ovf     = 1'b0;
      w_new     = w_acc_cur;
      case (r_op)
         c_OP_ADD: begin
            w_ovf = w_sum[WIDTH];
            w_new = ((SATURATE != 0) && w_ovf) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
         end
         c_OP_SUB: begin
            w_ovf = w_diff[WIDTH];
            w_new = ((SATURATE != 0) && w_ovf) ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
         end
         c_OP_LOAD: w_new = r_operand;
         default:   w_new = w_acc_cur;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
         r_sticky      <= '0;
         r_op          <= '0;
         r_chan        <= '0;
         r_operand     <= '0;
         r_result      <= '0;
         r_result_chan <= '0;
         r_result_ovf  <= 1'b0;
      end else if (ena) begin
         if (w_accept) begin
            r_op      <= bus.op;
            r_chan    <= bus.chan_sel;
            r_operand <= bus.operand;
         end
         if (r_state == S_EXEC) begin
            if (r_op != c_OP_READ) r_acc[r_chan] <= w_new;
            r_sticky[r_chan] <= (r_op == c_OP_LOAD) ? 1'b0 : (r_sticky[r_chan] | w_ovf);
            r_result      <= w_new;
            r_result_chan <= r_chan;
            r_result_ovf  <= w_ovf;
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = w_out_valid;
   assign bus.result      = r_result;
   assign bus.result_chan = r_result_chan;
   assign bus.result_ovf  = r_result_ovf;
   assign sticky_ovf      = r_sticky;
endmodule
`default_nettype wire
